// File: rtl/spi_master_multi_pkg.sv
// Shared types for the multi-mode, multi-CS SPI master.
package spi_master_multi_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SETUP = 2'd1,
    ST_XFER  = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Per-transfer mode bits captured when start is accepted.
  typedef struct packed {
    logic cpol;
    logic cpha;
    logic hold_cs;
  } xfer_cfg_t;

  function automatic int unsigned cs_sel_width(input int unsigned n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/spi_master_multi_edge_gen.sv
// SCK edge strobe generator: divider ticks every div+1 cycles while in_phase is high,
// and ticks during edge_en are numbered as alternating leading/trailing SCK edges.
module spi_master_multi_edge_gen #(
  parameter int unsigned DATA_W = 8,
  parameter int unsigned DIV_W  = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             in_phase,
  input  logic             edge_en,
  input  logic [DIV_W-1:0] div,
  output logic             tick_c,
  output logic             lead_stb_c,
  output logic             trail_stb_c,
  output logic             last_edge_c
);

  localparam int unsigned EDGES  = 2 * DATA_W;
  localparam int unsigned ECNT_W = $clog2(EDGES);

  logic [DIV_W-1:0]  cnt_q, cnt_d;
  logic [ECNT_W-1:0] edge_q, edge_d;

  // Both counters clear whenever in_phase is low.
  always_comb begin
    tick_c = in_phase && (cnt_q == div);
    cnt_d  = cnt_q;
    edge_d = edge_q;
    if (!in_phase) begin
      cnt_d  = '0;
      edge_d = '0;
    end else if (tick_c) begin
      cnt_d = '0;
      if (edge_en) edge_d = edge_q + ECNT_W'(1);
    end else begin
      cnt_d = cnt_q + DIV_W'(1);
    end
  end

  assign lead_stb_c  = tick_c && edge_en && !edge_q[0];
  assign trail_stb_c = tick_c && edge_en && edge_q[0];
  assign last_edge_c = tick_c && edge_en && (edge_q == ECNT_W'(EDGES - 1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt_q  <= '0;
      edge_q <= '0;
    end else begin
      cnt_q  <= cnt_d;
      edge_q <= edge_d;
    end
  end

endmodule

// File: rtl/spi_master_multi.sv
// SPI master with runtime CPOL/CPHA, runtime SCK divider, N chip selects and CS hold
// across multi-word frames. SCK is a registered output driven from clk-domain edge strobes.
module spi_master_multi
  import spi_master_multi_pkg::*;
#(
  parameter  int unsigned DATA_W   = 8,
  parameter  int unsigned CS_COUNT = 4,
  parameter  int unsigned DIV_W    = 8,
  localparam int unsigned CS_SEL_W = cs_sel_width(CS_COUNT)
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic [DATA_W-1:0]   d_in,
  input  logic [CS_SEL_W-1:0] cs_sel,
  input  logic                cpol,
  input  logic                cpha,
  input  logic [DIV_W-1:0]    div,
  input  logic                hold_cs,
  output logic [DATA_W-1:0]   d_out,
  output logic                busy,
  output logic                done,
  input  logic                miso,
  output logic                mosi,
  output logic                spi_clk,
  output logic [CS_COUNT-1:0] cs_n
);

  state_e              state_q, state_d;
  xfer_cfg_t           cfg_q, cfg_d;
  logic [DIV_W-1:0]    div_q, div_d;
  logic [CS_SEL_W-1:0] cs_sel_q, cs_sel_d;
  logic [DATA_W-1:0]   tx_q, tx_d;
  logic [DATA_W-1:0]   rx_q, rx_d;
  logic [DATA_W-1:0]   d_out_q, d_out_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                mosi_q, mosi_d;
  logic                sclk_q, sclk_d;
  logic [CS_COUNT-1:0] cs_n_q, cs_n_d;

  logic                tick_c, lead_c, trail_c, last_c;
  logic                sample_c, shift_c;
  logic [CS_COUNT-1:0] sel_dec_c, cur_dec_c;

  spi_master_multi_edge_gen #(
    .DATA_W (DATA_W),
    .DIV_W  (DIV_W)
  ) u_edge_gen (
    .clk         (clk),
    .reset       (reset),
    .in_phase    ((state_q == ST_SETUP) || (state_q == ST_XFER)),
    .edge_en     (state_q == ST_XFER),
    .div         (div_q),
    .tick_c      (tick_c),
    .lead_stb_c  (lead_c),
    .trail_stb_c (trail_c),
    .last_edge_c (last_c)
  );

  // Active-low one-hot decode; an out-of-range index selects nothing.
  always_comb begin
    sel_dec_c = '1;
    cur_dec_c = '1;
    for (int unsigned i = 0; i < CS_COUNT; i++) begin
      if (cs_sel == CS_SEL_W'(i))   sel_dec_c[i] = 1'b0;
      if (cs_sel_q == CS_SEL_W'(i)) cur_dec_c[i] = 1'b0;
    end
  end

  assign sample_c = cfg_q.cpha ? trail_c : lead_c;
  assign shift_c  = cfg_q.cpha ? lead_c  : (trail_c && !last_c);

  always_comb begin
    state_d  = state_q;
    cfg_d    = cfg_q;
    div_d    = div_q;
    cs_sel_d = cs_sel_q;
    tx_d     = tx_q;
    rx_d     = rx_q;
    d_out_d  = d_out_q;
    busy_d   = busy_q;
    done_d   = 1'b0;
    mosi_d   = mosi_q;
    sclk_d   = sclk_q;
    cs_n_d   = cs_n_q;

    case (state_q)
      ST_IDLE: begin
        sclk_d = cfg_q.cpol;
        if (start) begin
          state_d       = ST_SETUP;
          cfg_d.cpol    = cpol;
          cfg_d.cpha    = cpha;
          cfg_d.hold_cs = hold_cs;
          div_d         = div;
          cs_sel_d      = cs_sel;
          tx_d          = d_in;
          rx_d          = '0;
          busy_d        = 1'b1;
          mosi_d        = d_in[DATA_W-1];
          sclk_d        = cpol;
          // A held CS for a different slave is released before the new one asserts.
          cs_n_d        = (cs_n_q == sel_dec_c) ? cs_n_q : '1;
        end
      end
      ST_SETUP: begin
        cs_n_d = cur_dec_c;
        if (tick_c) state_d = ST_XFER;
      end
      ST_XFER: begin
        if (lead_c || trail_c) sclk_d = ~sclk_q;
        if (sample_c) rx_d = {rx_q[DATA_W-2:0], miso};
        // cpha=1 re-presents the current MSB on its leading edge; cpha=0 moves to the next bit.
        if (shift_c) begin
          mosi_d = cfg_q.cpha ? tx_q[DATA_W-1] : tx_q[DATA_W-2];
          tx_d   = {tx_q[DATA_W-2:0], 1'b0};
        end
        if (last_c) state_d = ST_DONE;
      end
      ST_DONE: begin
        state_d = ST_IDLE;
        d_out_d = rx_q;
        done_d  = 1'b1;
        busy_d  = 1'b0;
        if (!cfg_q.hold_cs) cs_n_d = '1;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q  <= ST_IDLE;
      cfg_q    <= '0;
      div_q    <= '0;
      cs_sel_q <= '0;
      tx_q     <= '0;
      rx_q     <= '0;
      d_out_q  <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      mosi_q   <= 1'b0;
      sclk_q   <= 1'b0;
      cs_n_q   <= '1;
    end else begin
      state_q  <= state_d;
      cfg_q    <= cfg_d;
      div_q    <= div_d;
      cs_sel_q <= cs_sel_d;
      tx_q     <= tx_d;
      rx_q     <= rx_d;
      d_out_q  <= d_out_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      mosi_q   <= mosi_d;
      sclk_q   <= sclk_d;
      cs_n_q   <= cs_n_d;
    end
  end

  assign d_out   = d_out_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign mosi    = mosi_q;
  assign spi_clk = sclk_q;
  assign cs_n    = cs_n_q;

endmodule
